jk_excitation_driver: RTL and testbench

Drives the J/K inputs of a downstream JK flip-flop so that its `q` output follows a loaded target bit sequence, using the JK excitation table. It also checks the flip-flop's returned `q` against each target bit. This is the producer end of the J/K interface that the existing JK flip-flop consumes. It is used as a built-in stimulus and self-check source for JK flip-flop instances.

---
 rtl/jk_excitation_driver.sv | 145 ++++++++++++++
 tb/tb_jk_excitation_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// Drives J/K of a downstream JK flip-flop so its q follows a loaded target word, checking q on return.
// Optional build macro JK_TOGGLE_EN: required transitions are driven as J/K=1/1 instead of set/reset.
module jk_excitation_driver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             jk_j,
    output logic             jk_k,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       dbg_state
);
    // Handshake: a word is taken on any rising edge where load_valid & load_ready are both 1.
    localparam int BC_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              m_q, m_d;
    logic              j_q, j_d, k_q, k_d;
    logic              v1_q, v1_d, v2_q, v2_d;
    logic              exp_q, exp_d;
    logic              done_q, done_d;
    logic              mismatch_q, mismatch_d;
    logic [CNT_W-1:0]  err_q, err_d;

    function automatic logic [1:0] excite(input logic m, input logic t);
        logic [1:0] jk;
        jk = 2'b00;
        if (m != t) begin
`ifdef JK_TOGGLE_EN
            jk = 2'b11;
`else
            jk = {t, ~t};
`endif
        end
        return jk;
    endfunction

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        m_d        = m_q;
        j_d        = 1'b0;
        k_d        = 1'b0;
        v1_d       = 1'b0;
        v2_d       = v1_q;
        exp_d      = m_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        err_d      = err_q;

        // Bit issued two edges ago: v2_q/exp_q carry its target into this edge's compare.
        if (v2_q && (q_fb != exp_q)) begin
            mismatch_d = 1'b1;
            if (err_q != {CNT_W{1'b1}}) err_d = err_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d    = DRIVE;
                    sr_d       = load_data >> 1;
                    {j_d, k_d} = excite(q_fb, load_data[0]);
                    m_d        = load_data[0];
                    bit_cnt_d  = BC_W'(1);
                    v1_d       = 1'b1;
                    mismatch_d = 1'b0;
                    err_d      = '0;
                end
            end
            DRIVE: begin
                if (bit_cnt_q == BC_W'(WIDTH)) begin
                    state_d = CHECK;
                end else begin
                    {j_d, k_d} = excite(m_q, sr_q[0]);
                    m_d        = sr_q[0];
                    sr_d       = sr_q >> 1;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    v1_d       = 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            m_q        <= 1'b0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            exp_q      <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            m_q        <= m_d;
            j_q        <= j_d;
            k_q        <= k_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            exp_q      <= exp_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign jk_j       = j_q;
    assign jk_k       = k_q;
    assign done       = done_q;
    assign mismatch   = mismatch_q;
    assign err_cnt    = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver with a behavioural JK flip-flop closing the loop.
module tb_jk_excitation_driver;
    localparam int W = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [W-1:0]  load_data = '0;
    logic          jk_j, jk_k;
    logic          q_fb;
    logic          busy, done, mismatch;
    logic [CW-1:0] err_cnt;
    logic [1:0]    dbg_state;

    logic ff_q = 1'b0;
    logic force_zero = 1'b0;

    int checks = 0;
    int failures = 0;

    jk_excitation_driver #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .jk_j(jk_j), .jk_k(jk_k), .q_fb(q_fb), .busy(busy),
        .done(done), .mismatch(mismatch), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference JK flip-flop in the loop.
    always @(posedge clk) begin
        case ({jk_j, jk_k})
            2'b10:   ff_q <= 1'b1;
            2'b01:   ff_q <= 1'b0;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
        endcase
    end

    assign q_fb = force_zero ? 1'b0 : ff_q;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One word from accept to done, every driven J/K and the final status checked.
    task automatic run_word(input logic [W-1:0] data, input bit f0);
        logic [1:0] exp_jk [W];
        logic m, t;
        int errs;
        @(negedge clk);
        force_zero = f0;
        m = f0 ? 1'b0 : ff_q;
        errs = 0;
        for (int n = 0; n < W; n++) begin
            t = data[n];
            if (t == m) exp_jk[n] = 2'b00;
`ifdef JK_TOGGLE_EN
            else exp_jk[n] = 2'b11;
`else
            else exp_jk[n] = t ? 2'b10 : 2'b01;
`endif
            if (f0 && t) errs++;
            m = t;
        end
        check("ready_before_load", load_ready, 1);
        load_valid = 1'b1;
        load_data  = data;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = W'($urandom);
        for (int n = 0; n < W; n++) begin
            if (n > 0) @(negedge clk);
            check($sformatf("jk_bit%0d_%0h", n, data), {jk_j, jk_k}, exp_jk[n]);
            check("busy_drive", busy, 1);
            check("done_drive", done, 0);
        end
        @(negedge clk);
        check("jk_after_word", {jk_j, jk_k}, 2'b00);
        check("busy_check", busy, 1);
        check("ready_check", load_ready, 0);
        check("done_check", done, 0);
        @(negedge clk);
        check($sformatf("done_%0h", data), done, 1);
        check("ready_done", load_ready, 1);
        check("busy_done", busy, 0);
        check($sformatf("mismatch_%0h", data), mismatch, (errs != 0));
        check($sformatf("err_cnt_%0h", data), err_cnt, errs);
        if (!f0) check("q_final", ff_q, data[W-1]);
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("mismatch_hold", mismatch, (errs != 0));
        check("err_hold", err_cnt, errs);
        force_zero = 1'b0;
    endtask

    initial begin
        int acc_cyc [2];
        int accepts, low1, low2;
        logic r;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("rst_ready", load_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_jk", {jk_j, jk_k}, 2'b00);
        check("rst_mismatch", mismatch, 0);
        check("rst_err", err_cnt, 0);
        reset = 1'b1;

        run_word(8'h00, 1'b0);
        run_word(8'hA5, 1'b0);
        run_word(8'hFF, 1'b1);
        run_word(8'h3C, 1'b0);

        // load_valid held high across two words: accepts WIDTH+2 apart, none lost.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'h0F;
        accepts = 0; low1 = 0; low2 = 0;
        acc_cyc[0] = -1; acc_cyc[1] = -1;
        for (int i = 0; i < 30; i++) begin
            r = load_ready;
            if (!r && accepts == 1) low1++;
            if (!r && accepts == 2) low2++;
            @(posedge clk);
            if (r && load_valid) begin
                if (accepts < 2) acc_cyc[accepts] = i;
                accepts++;
                #1;
                if (accepts == 1) load_data = 8'hF0;
                else load_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_accepts", accepts, 2);
        check("b2b_first", acc_cyc[0], 0);
        check("b2b_spacing", acc_cyc[1] - acc_cyc[0], W + 2);
        check("b2b_ready_low1", low1, W + 1);
        check("b2b_ready_low2", low2, W + 1);
        check("b2b_q_final", ff_q, 1);
        check("b2b_mismatch", mismatch, 0);

        // Reset pulsed after bit 4 is registered: immediate return to reset values, no done.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        @(posedge clk);
        #1 load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("pre_rst_busy", busy, 1);
        #1 reset = 1'b0;
        #1;
        check("midrst_jk", {jk_j, jk_k}, 2'b00);
        check("midrst_busy", busy, 0);
        check("midrst_ready", load_ready, 1);
        check("midrst_done", done, 0);
        check("midrst_err", err_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            check("no_done_after_rst", {done, busy}, 2'b00);
        end
        run_word(8'h5A, 1'b0);

        // Random words, some with q_fb stuck at 0.
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_word(W'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
